// File: rtl/char_lcd_pkg.sv
// Shared definitions for the HD44780-compatible character-LCD controller.
// Holds the command bytes, the DDRAM row base table, the sequencer state enum and
// the transfer-phase enum used by char_lcd_ctrl and char_lcd_xfer.
// Optional feature macro: LCD_4BIT_EN selects the 4-bit bus function-set value.

package char_lcd_pkg;

`ifdef LCD_4BIT_EN
  localparam logic [7:0] FUNC_SET = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
`else
  localparam logic [7:0] FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
`endif
  localparam logic [7:0] DISP_ON   = 8'h0C;  // display on, cursor off, blink off
  localparam logic [7:0] ENTRY     = 8'h06;  // increment address, no shift
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] SET_DDRAM = 8'h80;

  // Wake-up nibbles that switch the panel into 4-bit mode.
  localparam logic [3:0] WAKE_NIB  = 4'h3;
  localparam logic [3:0] BUS4_NIB  = 4'h2;

  typedef enum logic [2:0] {
    StPwrWait,
    StWake,
    StInit,
    StSetAddr,
    StWrChar
  } lcd_state_e;

  typedef enum logic [1:0] {
    PhIdle,
    PhSetup,
    PhHigh,
    PhWait
  } xfer_phase_e;

  function automatic logic [7:0] row_base(input logic [1:0] row);
    unique case (row)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    unique case (step)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY;
      default: return CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/char_lcd_xfer.sv
// One-transfer timing engine for the LCD bus. On start it latches rs/data, holds
// them E_SETUP_CYC cycles, raises lcd_e for E_HIGH_CYC cycles, then waits
// CLR_WAIT_CYC (long_wait) or CMD_WAIT_CYC cycles with rs/data still held.
// done pulses in the last wait cycle; a start in that same cycle begins the next
// transfer immediately. rs/data stay on the bus until the next start.
// Ports: clk, reset (async, active-low), start, rs, data[7:0], long_wait in;
//        done, lcd_e, lcd_rs, lcd_db[7:0] out.
// E_SETUP_CYC, E_HIGH_CYC and both waits must be at least 1.

module char_lcd_xfer
  import char_lcd_pkg::*;
#(
  parameter int unsigned E_SETUP_CYC  = 2,
  parameter int unsigned E_HIGH_CYC   = 25,
  parameter int unsigned CMD_WAIT_CYC = 2_500,
  parameter int unsigned CLR_WAIT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_db
);

  xfer_phase_e phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wait_len;
  logic        e_q, e_d;
  logic        rs_q, rs_d;
  logic [7:0]  db_q, db_d;
  logic        long_q, long_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PhIdle;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= '0;
      long_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    e_d      = e_q;
    rs_d     = rs_q;
    db_d     = db_q;
    long_d   = long_q;
    done     = 1'b0;
    wait_len = long_q ? CLR_WAIT_CYC : CMD_WAIT_CYC;

    unique case (phase_q)
      PhIdle: ;
      PhSetup: begin
        if (cnt_q == E_SETUP_CYC - 1) begin
          phase_d = PhHigh;
          cnt_d   = '0;
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PhHigh: begin
        if (cnt_q == E_HIGH_CYC - 1) begin
          phase_d = PhWait;
          cnt_d   = '0;
          e_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PhWait: begin
        if (cnt_q == wait_len - 1) begin
          done    = 1'b1;
          phase_d = PhIdle;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: phase_d = PhIdle;
    endcase

    if (start) begin
      phase_d = PhSetup;
      cnt_d   = '0;
      e_d     = 1'b0;
      rs_d    = rs;
      db_d    = data;
      long_d  = long_wait;
    end
  end

  assign lcd_e  = e_q;
  assign lcd_rs = rs_q;
  assign lcd_db = db_q;

endmodule

// File: rtl/char_lcd_ctrl.sv
// HD44780-compatible character-LCD controller. Keeps a ROWS x COLS character
// buffer (reset to spaces, host-writable every cycle), runs the power-on init
// sequence and then refreshes the panel forever: set-address, COLS chars, per row.
// Ports: clk, reset (async, active-low), wr_en, wr_addr (row*COLS+col), wr_data in;
//        init_done, lcd_e, lcd_rs, lcd_rw (always 0), lcd_db[7:0] out.
// Macro LCD_4BIT_EN: 4-bit bus on lcd_db[7:4], bytes sent high nibble first,
// preceded by the 3,3,3,2 wake-up nibbles. Undefined: plain 8-bit bus.

module char_lcd_ctrl
  import char_lcd_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned COLS         = 16,
  parameter int unsigned PWR_WAIT_CYC = CLK_HZ / 25,      // 40 ms
  parameter int unsigned E_SETUP_CYC  = 2,
  parameter int unsigned E_HIGH_CYC   = 25,
  parameter int unsigned CMD_WAIT_CYC = CLK_HZ / 20_000,  // 50 us
  parameter int unsigned CLR_WAIT_CYC = CLK_HZ / 500,     // 2 ms
  localparam int unsigned NCHAR = ROWS * COLS,
  localparam int unsigned AW    = (NCHAR > 1) ? $clog2(NCHAR) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          init_done,
  output logic          lcd_e,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic [7:0]    lcd_db
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

  lcd_state_e    state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [1:0]    step_q, step_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          init_done_q, init_done_d;
  logic [7:0]    buf_q [NCHAR];

  logic          adv;
  logic [7:0]    nxt_byte;
  logic [AW-1:0] rd_idx;
  logic          x_start, x_rs, x_long, x_done;
  logic [7:0]    x_data;

`ifdef LCD_4BIT_EN
  // nib_q: high nibble of cur_q already sent, low nibble pending.
  logic          nib_q, nib_d;
  logic [7:0]    cur_q, cur_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nib_q <= 1'b0;
      cur_q <= '0;
    end else begin
      nib_q <= nib_d;
      cur_q <= cur_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StPwrWait;
      cnt_q       <= '0;
      step_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      row_q       <= row_d;
      col_q       <= col_d;
      init_done_q <= init_done_d;
    end
  end

  // Out-of-range addresses are dropped; a same-cycle refresh read sees the old byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCHAR; i++) buf_q[i] <= 8'h20;
    end else if (wr_en && (32'(wr_addr) < NCHAR)) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    row_d       = row_q;
    col_d       = col_q;
    init_done_d = init_done_q;
    adv         = 1'b0;
    nxt_byte    = '0;
    rd_idx      = '0;
    x_start     = 1'b0;
    x_rs        = 1'b0;
    x_long      = 1'b0;
    x_data      = '0;
`ifdef LCD_4BIT_EN
    nib_d       = nib_q;
    cur_d       = cur_q;
`endif

    if (state_q == StPwrWait) begin
      if (cnt_q == PWR_WAIT_CYC - 1) adv = 1'b1;
      else                           cnt_d = cnt_q + 32'd1;
    end else if (x_done) begin
`ifdef LCD_4BIT_EN
      if (state_q != StWake && !nib_q) begin
        nib_d   = 1'b1;
        x_start = 1'b1;
        x_rs    = (state_q == StWrChar);
        x_data  = {cur_q[3:0], 4'h0};
        x_long  = (state_q == StInit) && (cur_q == CLEAR);
      end else begin
        adv = 1'b1;
      end
`else
      adv = 1'b1;
`endif
    end

    if (adv) begin
      unique case (state_q)
        StPwrWait: begin
          step_d = '0;
`ifdef LCD_4BIT_EN
          state_d = StWake;
`else
          state_d = StInit;
`endif
        end
        StWake: begin
          if (step_q == 2'd3) begin
            state_d = StInit;
            step_d  = '0;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
        StInit: begin
          if (step_q == 2'd3) begin
            state_d     = StSetAddr;
            row_d       = '0;
            init_done_d = 1'b1;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
        StSetAddr: begin
          state_d = StWrChar;
          col_d   = '0;
        end
        StWrChar: begin
          if (col_q == CW'(COLS - 1)) begin
            col_d   = '0;
            row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            state_d = StSetAddr;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        default: state_d = StPwrWait;
      endcase

      // The byte of the transfer that starts now, taken from the next-state values.
      rd_idx = AW'(32'(row_d) * COLS + 32'(col_d));
      unique case (state_d)
        StWake:    nxt_byte = {(step_d == 2'd3) ? BUS4_NIB : WAKE_NIB, 4'h0};
        StInit:    nxt_byte = init_cmd(step_d);
        StSetAddr: nxt_byte = SET_DDRAM | row_base(2'(row_d));
        StWrChar:  nxt_byte = buf_q[rd_idx];
        default:   nxt_byte = '0;
      endcase

      x_start = 1'b1;
      x_rs    = (state_d == StWrChar);
`ifdef LCD_4BIT_EN
      nib_d  = 1'b0;
      cur_d  = nxt_byte;
      x_data = {nxt_byte[7:4], 4'h0};
      x_long = (state_d == StWake);
`else
      x_data = nxt_byte;
      x_long = (state_d == StInit) && (nxt_byte == CLEAR);
`endif
    end
  end

  char_lcd_xfer #(
    .E_SETUP_CYC (E_SETUP_CYC),
    .E_HIGH_CYC  (E_HIGH_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC)
  ) u_xfer (
    .clk      (clk),
    .reset    (reset),
    .start    (x_start),
    .rs       (x_rs),
    .data     (x_data),
    .long_wait(x_long),
    .done     (x_done),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_db   (lcd_db)
  );

  assign init_done = init_done_q;
  assign lcd_rw    = 1'b0;

endmodule
